// File: rtl/common_pkg.sv
// common_pkg: scalar types shared across the pipeline
package common_pkg;
  typedef logic [63:0] u64;
endpackage

// File: rtl/mdu_sched_pkg.sv
// mdu_sched_pkg: M-extension op codes, scheduler states, widths and op decode helpers
package mdu_sched_pkg;
  import common_pkg::*;
  localparam int MDU_XLEN = 64;
  localparam int MDU_WLEN = 32;
  typedef enum logic [3:0] {MUL, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW} mdu_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} mdu_state_t;
  function automatic logic op_is_w(input mdu_op_t o);
    return o inside {MULW, DIVW, DIVUW, REMW, REMUW};
  endfunction
  function automatic logic op_is_mul(input mdu_op_t o);
    return o inside {MUL, MULW};
  endfunction
  function automatic logic op_is_signed(input mdu_op_t o);
    return o inside {DIV, REM, DIVW, REMW};
  endfunction
  function automatic logic op_is_rem(input mdu_op_t o);
    return o inside {REM, REMU, REMW, REMUW};
  endfunction
  function automatic u64 sext_w(input u64 v);
    return {{32{v[31]}}, v[31:0]};
  endfunction
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: restoring divider on operand magnitudes, one quotient bit per step
// Ports: clk/reset; i_start latches i_a/i_b (i_signed, i_w select interpretation);
//        i_step retires one bit; o_q_nxt/o_r_nxt are magnitudes after the current step;
//        o_neg_q/o_neg_r tell the caller which results need negating.
module mdu_div_core
  import common_pkg::*;
  import mdu_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_step,
  input  logic i_signed,
  input  logic i_w,
  input  u64   i_a,
  input  u64   i_b,
  output u64   o_q_nxt,
  output u64   o_r_nxt,
  output logic o_neg_q,
  output logic o_neg_r
);
  u64 r_rem, r_dvd, r_dvs;
  logic r_neg_q, r_neg_r;
  u64 w_ea, w_eb, w_ma, w_mb;
  logic w_sa, w_sb, w_qb;
  logic [64:0] w_sh, w_trial;
  assign w_ea = i_w ? (i_signed ? sext_w(i_a) : {32'b0, i_a[31:0]}) : i_a;
  assign w_eb = i_w ? (i_signed ? sext_w(i_b) : {32'b0, i_b[31:0]}) : i_b;
  assign w_sa = i_signed & w_ea[63];
  assign w_sb = i_signed & w_eb[63];
  assign w_ma = w_sa ? -w_ea : w_ea;
  assign w_mb = w_sb ? -w_eb : w_eb;
  // r_dvd shifts dividend bits out of the top while quotient bits enter at the bottom
  assign w_sh = {r_rem, r_dvd[63]};
  assign w_trial = w_sh - {1'b0, r_dvs};
  assign w_qb = ~w_trial[64];
  assign o_r_nxt = w_qb ? w_trial[63:0] : w_sh[63:0];
  assign o_q_nxt = {r_dvd[62:0], w_qb};
  assign o_neg_q = r_neg_q;
  assign o_neg_r = r_neg_r;
  always_ff @(posedge clk)
    if (reset) begin
      r_rem <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_start) begin
      r_rem <= '0;
      r_dvd <= i_w ? {w_ma[31:0], 32'b0} : w_ma;
      r_dvs <= w_mb;
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
    end else if (i_step) begin
      r_rem <= o_r_nxt;
      r_dvd <= o_q_nxt;
    end
endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle RV64 M-extension multiply/divide scheduler
// Ports: clk/reset; req_valid/req_ready/op/a/b request handshake; flush kills in-flight op;
//        resp_valid one-cycle pulse with result (held until next completion); busy = stall.
module mdu_sched
  import common_pkg::*;
  import mdu_sched_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req_valid,
  output logic    req_ready,
  input  mdu_op_t op,
  input  u64      a,
  input  u64      b,
  input  logic    flush,
  output logic    resp_valid,
  output u64      result,
  output logic    busy
);
  mdu_state_t r_state;
  mdu_op_t r_op;
  logic [6:0] r_cnt;
  u64 r_acc, r_mcand, r_mplier, r_result;
  logic w_accept, w_is_w, w_dz, w_ovf, w_special;
  u64 w_ea, w_eb, w_spec_res, w_acc_nxt, w_mul_res, w_q_nxt, w_r_nxt, w_q, w_r, w_dres, w_div_res;
  logic w_neg_q, w_neg_r;
  assign w_accept = req_valid & (r_state == ST_IDLE) & ~flush & ~reset;
  assign w_is_w = op_is_w(op);
  assign w_ea = w_is_w ? sext_w(a) : a;
  assign w_eb = w_is_w ? sext_w(b) : b;
  assign w_dz = w_eb == '0;
  assign w_ovf = op_is_signed(op) & (w_is_w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                                            : (a == {1'b1, 63'b0} && b == '1));
  assign w_special = ~op_is_mul(op) & (w_dz | w_ovf);
  assign w_spec_res = w_dz ? (op_is_rem(op) ? w_ea : '1) : (op_is_rem(op) ? '0 : w_ea);
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_res = op_is_w(r_op) ? sext_w(w_acc_nxt) : w_acc_nxt;
  assign w_q = w_neg_q ? -w_q_nxt : w_q_nxt;
  assign w_r = w_neg_r ? -w_r_nxt : w_r_nxt;
  assign w_dres = op_is_rem(r_op) ? w_r : w_q;
  assign w_div_res = op_is_w(r_op) ? sext_w(w_dres) : w_dres;
  assign req_ready = r_state == ST_IDLE;
  assign busy = r_state != ST_IDLE;
  assign resp_valid = (r_state == ST_DONE) & ~flush & ~reset;
  assign result = r_result;
  mdu_div_core u_div (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept),
    .i_step   (r_state == ST_DIV),
    .i_signed (op_is_signed(op)),
    .i_w      (w_is_w),
    .i_a      (a),
    .i_b      (b),
    .o_q_nxt  (w_q_nxt),
    .o_r_nxt  (w_r_nxt),
    .o_neg_q  (w_neg_q),
    .o_neg_r  (w_neg_r)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= ST_IDLE;
      r_op <= MUL;
      r_cnt <= '0;
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      r_result <= '0;
    end else if (flush) r_state <= ST_IDLE;
    else case (r_state)
      ST_IDLE: if (req_valid) begin
        r_op <= op;
        r_cnt <= w_is_w ? 7'(MDU_WLEN) : 7'(MDU_XLEN);
        r_acc <= '0;
        r_mcand <= w_is_w ? {32'b0, a[31:0]} : a;
        r_mplier <= w_is_w ? {32'b0, b[31:0]} : b;
        if (w_special) r_result <= w_spec_res;
        r_state <= op_is_mul(op) ? ST_MUL : w_special ? ST_DONE : ST_DIV;
      end
      ST_MUL: begin
        r_acc <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt <= r_cnt - 7'd1;
        if (r_cnt == 7'd1) begin
          r_result <= w_mul_res;
          r_state <= ST_DONE;
        end
      end
      ST_DIV: begin
        r_cnt <= r_cnt - 7'd1;
        if (r_cnt == 7'd1) begin
          r_result <= w_div_res;
          r_state <= ST_DONE;
        end
      end
      default: r_state <= ST_IDLE;
    endcase
endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed self-checking bench for mdu_sched
module tb_mdu_sched;
  import common_pkg::*;
  import mdu_sched_pkg::*;
  typedef struct {mdu_op_t o; u64 x; u64 y; u64 r; int lat;} vec_t;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, flush = 1'b0;
  mdu_op_t op = MUL;
  u64 a = '0, b = '0;
  logic req_ready, resp_valid, busy;
  u64 result;
  int n_run = 0, n_fail = 0;
  mdu_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .result     (result),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  task automatic run_op(input mdu_op_t o, input u64 x, input u64 y, output int lat, output u64 res, output logic busy_all);
    lat = 0;
    res = '0;
    busy_all = 1'b1;
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      busy_all &= busy;
      if (resp_valid) begin
        lat = k;
        res = result;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready got %b exp 1", req_ready); end
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset resp_valid got %b exp 0", resp_valid); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", busy); end
    n_run++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset result got %h exp 0", result); end
  endtask
  task automatic test_mul;
    vec_t t[4];
    int lat;
    u64 res;
    logic bz;
    t = '{'{MUL, 64'd3, 64'd5, 64'd15, 65},
          '{MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33},
          '{MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65},
          '{MULW, 64'h1_0000_0003, 64'd5, 64'd15, 33}};
    foreach (t[i]) begin
      run_op(t[i].o, t[i].x, t[i].y, lat, res, bz);
      n_run++; if (res !== t[i].r) begin n_fail++; $display("FAIL mul[%0d] %s result got %h exp %h", i, t[i].o.name(), res, t[i].r); end
      n_run++; if (lat != t[i].lat) begin n_fail++; $display("FAIL mul[%0d] %s latency got %0d exp %0d", i, t[i].o.name(), lat, t[i].lat); end
      n_run++; if (bz !== 1'b1) begin n_fail++; $display("FAIL mul[%0d] %s busy dropped got %b exp 1", i, t[i].o.name(), bz); end
    end
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mul pulse resp_valid got %b exp 0", resp_valid); end
    n_run++; if (result !== 64'd15) begin n_fail++; $display("FAIL mul hold result got %h exp f", result); end
    n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mul idle req_ready got %b exp 1", req_ready); end
  endtask
  task automatic test_div;
    vec_t t[8];
    int lat;
    u64 res;
    logic bz;
    t = '{'{DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65},
          '{REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65},
          '{DIVU, 64'd100, 64'd7, 64'd14, 65},
          '{REMU, 64'd100, 64'd7, 64'd2, 65},
          '{REM, 64'd7, -64'sd2, 64'd1, 65},
          '{DIVW, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33},
          '{REMUW, 64'hFFFF_FFF9, 64'h10, 64'd9, 33},
          '{DIVUW, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33}};
    foreach (t[i]) begin
      run_op(t[i].o, t[i].x, t[i].y, lat, res, bz);
      n_run++; if (res !== t[i].r) begin n_fail++; $display("FAIL div[%0d] %s result got %h exp %h", i, t[i].o.name(), res, t[i].r); end
      n_run++; if (lat != t[i].lat) begin n_fail++; $display("FAIL div[%0d] %s latency got %0d exp %0d", i, t[i].o.name(), lat, t[i].lat); end
    end
  endtask
  task automatic test_special;
    vec_t t[6];
    int lat;
    u64 res;
    logic bz;
    t = '{'{DIVU, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1},
          '{REMU, 64'd9, 64'd0, 64'd9, 1},
          '{DIVW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1},
          '{REMW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1},
          '{DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1},
          '{DIVW, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1}};
    foreach (t[i]) begin
      run_op(t[i].o, t[i].x, t[i].y, lat, res, bz);
      n_run++; if (res !== t[i].r) begin n_fail++; $display("FAIL special[%0d] %s result got %h exp %h", i, t[i].o.name(), res, t[i].r); end
      n_run++; if (lat != t[i].lat) begin n_fail++; $display("FAIL special[%0d] %s latency got %0d exp %0d", i, t[i].o.name(), lat, t[i].lat); end
    end
  endtask
  task automatic test_abort(input logic use_reset);
    int lat, seen;
    u64 res, keep;
    logic bz;
    run_op(MUL, 64'd3, 64'd5, lat, res, bz);
    n_run++; if (res !== 64'd15) begin n_fail++; $display("FAIL abort(%0b) setup result got %h exp f", use_reset, res); end
    keep = use_reset ? 64'd0 : 64'd15;
    seen = 0;
    @(negedge clk);
    op = MUL;
    a = 64'd7;
    b = 64'd9;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (resp_valid) seen++;
      @(posedge clk);
      #1;
    end
    if (use_reset) reset = 1'b1;
    else flush = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort(%0b) req_ready got %b exp 1", use_reset, req_ready); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort(%0b) busy got %b exp 0", use_reset, busy); end
    n_run++; if (result !== keep) begin n_fail++; $display("FAIL abort(%0b) result got %h exp %h", use_reset, result, keep); end
    for (int k = 0; k < 70; k++) begin
      if (resp_valid) seen++;
      @(posedge clk);
      #1;
    end
    n_run++; if (seen != 0) begin n_fail++; $display("FAIL abort(%0b) stray resp_valid count got %0d exp 0", use_reset, seen); end
    run_op(MUL, 64'd2, 64'd2, lat, res, bz);
    n_run++; if (res !== 64'd4) begin n_fail++; $display("FAIL abort(%0b) recovery result got %h exp 4", use_reset, res); end
    n_run++; if (lat != 65) begin n_fail++; $display("FAIL abort(%0b) recovery latency got %0d exp 65", use_reset, lat); end
  endtask
  task automatic test_flush_edges;
    @(negedge clk);
    op = DIVU;
    a = 64'd9;
    b = 64'd0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_done busy got %b exp 1", busy); end
    flush = 1'b1;
    #1;
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done resp_valid got %b exp 0", resp_valid); end
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_done req_ready got %b exp 1", req_ready); end
    @(negedge clk);
    op = MUL;
    a = 64'd1;
    b = 64'd1;
    req_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush = 1'b0;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_req busy got %b exp 0", busy); end
    n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_req req_ready got %b exp 1", req_ready); end
  endtask
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_edges();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
